// File: rtl/sdram_write_post_pkg.sv
`default_nettype none
// ============================================================================
// sdram_write_post_pkg : shared widths and FSM state encoding for the
//                        SDRAM write-posting stage.
// Revision 1.0
// ============================================================================
package sdram_write_post_pkg;

    localparam int ADDR_W_DEF     = 23;
    localparam int DATA_W_DEF     = 16;
    localparam int DEPTH_LOG2_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_GAP   = 2'd3
    } wpost_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_write_post_fifo.sv
`default_nettype none
// ============================================================================
// sdram_write_post_fifo : synchronous FIFO of {addr,data} write entries.
// Revision 1.0
// ============================================================================
module sdram_write_post_fifo
    import sdram_write_post_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  Push,
    input  logic [ADDR_W-1:0]     PushAddr,
    input  logic [DATA_W-1:0]     PushData,
    input  logic                  Pop,
    output logic [ADDR_W-1:0]     HeadAddr,
    output logic [DATA_W-1:0]     HeadData,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Full,
    output logic                  Empty
);

    localparam int                DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]    wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]      count_q, count_d;

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge Clk) begin
        if (Push) begin
            mem_q[wr_ptr_q] <= {PushAddr, PushData};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({Push, Pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (Push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (Pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_d;
        end
    end

    assign {HeadAddr, HeadData} = mem_q[rd_ptr_q];
    assign Count = count_q;
    assign Full  = (count_q == C_FULL);
    assign Empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_write_post.sv
`default_nettype none
// ============================================================================
// sdram_write_post : posts host writes into a FIFO, drains them to the SDRAM
//                    controller by req/ack, and orders reads behind them.
// Revision 1.0
// ============================================================================
module sdram_write_post
    import sdram_write_post_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              HEn,
    input  logic              HWr,
    input  logic              HRd,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [DATA_W-1:0] HData,
    output logic [DATA_W-1:0] HDataRd,
    output logic              HRdValid,
    output logic              HStall,
    output logic              HErr,
    output logic              CReq,
    output logic              CWe,
    output logic [ADDR_W-1:0] CAddr,
    output logic [DATA_W-1:0] CWData,
    input  logic              CAck,
    input  logic [DATA_W-1:0] CRData
);

    wpost_state_e          state_q, state_d;
    logic                  rdpend_q, rdpend_d;
    logic [ADDR_W-1:0]     rdaddr_q, rdaddr_d;
    logic                  herr_q, herr_d;
    logic                  creq_q, creq_d;
    logic                  cwe_q, cwe_d;
    logic [ADDR_W-1:0]     caddr_q, caddr_d;
    logic [DATA_W-1:0]     cwdata_q, cwdata_d;
    logic [DATA_W-1:0]     hdatard_q, hdatard_d;
    logic                  hrdvalid_q, hrdvalid_d;

    logic                  w_wr_req, w_rd_req, w_push, w_pop;
    logic                  w_full, w_empty;
    logic [DEPTH_LOG2:0]   w_count;
    logic [ADDR_W-1:0]     w_head_addr;
    logic [DATA_W-1:0]     w_head_data;

    assign w_wr_req = HEn & HWr;
    assign w_rd_req = HEn & HRd;
    // Full is taken from the registered count, so a same-cycle pop cannot admit a push.
    assign w_push   = w_wr_req & ~w_full & ~rdpend_q;

    sdram_write_post_fifo #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .Push     (w_push),
        .PushAddr (HAddr),
        .PushData (HData),
        .Pop      (w_pop),
        .HeadAddr (w_head_addr),
        .HeadData (w_head_data),
        .Count    (w_count),
        .Full     (w_full),
        .Empty    (w_empty)
    );

    always_comb begin
        state_d    = state_q;
        rdpend_d   = rdpend_q;
        rdaddr_d   = rdaddr_q;
        herr_d     = herr_q;
        creq_d     = creq_q;
        cwe_d      = cwe_q;
        caddr_d    = caddr_q;
        cwdata_d   = cwdata_q;
        hdatard_d  = hdatard_q;
        hrdvalid_d = 1'b0;
        w_pop      = 1'b0;

        if (w_rd_req && !rdpend_q) begin
            rdpend_d = 1'b1;
            rdaddr_d = HAddr;
        end
        if ((w_wr_req && (w_full || rdpend_q)) || (w_rd_req && rdpend_q)) begin
            herr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Queued writes always go ahead of a pending read.
                if (w_count != '0) begin
                    state_d  = ST_WRITE;
                    creq_d   = 1'b1;
                    cwe_d    = 1'b1;
                    caddr_d  = w_head_addr;
                    cwdata_d = w_head_data;
                end else if (rdpend_q) begin
                    state_d  = ST_READ;
                    creq_d   = 1'b1;
                    cwe_d    = 1'b0;
                    caddr_d  = rdaddr_q;
                end
            end
            ST_WRITE: begin
                if (CAck) begin
                    w_pop   = ~w_empty;
                    creq_d  = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_READ: begin
                if (CAck) begin
                    hdatard_d  = CRData;
                    hrdvalid_d = 1'b1;
                    rdpend_d   = 1'b0;
                    creq_d     = 1'b0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            rdpend_q   <= 1'b0;
            rdaddr_q   <= '0;
            herr_q     <= 1'b0;
            creq_q     <= 1'b0;
            cwe_q      <= 1'b0;
            caddr_q    <= '0;
            cwdata_q   <= '0;
            hdatard_q  <= '0;
            hrdvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdpend_q   <= rdpend_d;
            rdaddr_q   <= rdaddr_d;
            herr_q     <= herr_d;
            creq_q     <= creq_d;
            cwe_q      <= cwe_d;
            caddr_q    <= caddr_d;
            cwdata_q   <= cwdata_d;
            hdatard_q  <= hdatard_d;
            hrdvalid_q <= hrdvalid_d;
        end
    end

    assign HDataRd  = hdatard_q;
    assign HRdValid = hrdvalid_q;
    assign HStall   = w_full | rdpend_q;
    assign HErr     = herr_q;
    assign CReq     = creq_q;
    assign CWe      = cwe_q;
    assign CAddr    = caddr_q;
    assign CWData   = cwdata_q;

endmodule
`default_nettype wire
